alu_seq: RTL and testbench
==========================

// Module: alu_seq
// PURPOSE
//  Parametrised, multi-cycle successor to the 16-bit combinational ripple ALU.
//  Computes ADD/SUB/AND/OR over WIDTH bits, SLICE_W bits per clock, holding
//  the carry in a register between slices. Adds ZERO/CARRY/OVERFLOW flags
//  and valid/ready handshakes on both sides.
//  Sits between the queue datapath registers and the result writeback stage.
// PARAMETERS
//  WIDTH    16  operand/result width; must be a multiple of SLICE_W (static assert)
//  SLICE_W   4  bits processed per cycle; SLICE_W==WIDTH gives single-cycle operation
// PORTS
//  clk        in   1        single clock, rising edge
//  rst_n      in   1        asynchronous, active-low reset
//  in_valid   in   1        operand request valid
//  in_ready   out  1        block can accept a request
//  in_op      in   2        op[1]=0: arith (op[0]=0 ADD, 1 SUB); op[1]=1: logic (op[0]=0 AND, 1 OR)
//  in_a       in   WIDTH    operand A
//  in_b       in   WIDTH    operand B
//  out_valid  out  1        result valid
//  out_ready  in   1        consumer accepts result
//  out_result out  WIDTH    result
//  out_carry  out  1        arith carry-out; for SUB, 1 = no borrow; 0 for logic ops
//  out_ovf    out  1        signed overflow (arith only; 0 for logic ops)
//  out_zero   out  1        out_result == 0
// BEHAVIOUR
//  - Reset (async assert, sync deassert at the top level): state=IDLE;
//    in_ready=1; out_valid=0; result and all flags 0; slice count 0.
//  - FSM states:
//    IDLE --in_valid--> BUSY
//    BUSY --last slice--> DONE
//    DONE --out_ready--> IDLE
//  - Accept: in_valid & in_ready. Capture op, a and b. Carry register <= op[0]
//    for arith, 0 for logic. Slice index <= 0.
//  - in_ready = (state==IDLE) only. in_valid is ignored in BUSY and DONE,
//    with no back-to-back overlap.
//  - BUSY: each cycle compute slice k (bits k*SLICE_W +: SLICE_W) and write it
//    into the result register. For SUB, use B inverted. Update the carry
//    register, then k++.
//    NSLICE = WIDTH/SLICE_W. out_valid rises exactly NSLICE cycles after the
//    accept edge (SLICE_W=WIDTH -> 1 cycle).
//  - Flags, latched on the last slice:
//    carry = carry out of the MSB;
//    ovf = carry into the MSB ^ carry out of the MSB;
//    zero = full result == 0.
//  - DONE: out_valid=1. Outputs are held stable until out_ready. out_ready is
//    sampled in DONE only; out_ready in IDLE/BUSY has no effect.
//  - Handshake in DONE: out_valid drops the next cycle and in_ready rises.
//    The earliest next accept is the cycle after that.
//  - Reset mid-operation (BUSY or DONE): the operation is discarded, and
//    outputs and state return to reset values immediately.
//  - Operand and op changes after accept do not affect the in-flight result.
//  - Arithmetic is modulo 2^WIDTH; there is no saturation.
// STRUCTURE
//  - Shared include alu_defs.vh: op encodings (OP_ADD=2'b00, OP_SUB=2'b01,
//    OP_AND=2'b10, OP_OR=2'b11) and FSM state encodings (IDLE, BUSY, DONE).
//  - Sub-module alu_chunk: combinational SLICE_W-bit slice.
//    Inputs: op, a, b, cin. Outputs: o, cout, and the carry into its MSB
//    (for ovf). Built as a ripple chain.
//  - Top level: FSM, slice counter ($clog2(NSLICE) bits, min 1), operand
//    registers (muxed per slice index), carry register, result register,
//    flag registers.
// TESTING
//  1. WIDTH=16, SLICE_W=4. ADD 0xFFFF + 0x0001 -> result 0x0000, carry=1,
//     zero=1, ovf=0; out_valid exactly 4 cycles after accept.
//  2. SUB 0x0005 - 0x0007 -> 0xFFFE, carry=0, ovf=0, zero=0.
//     SUB 0x0007 - 0x0005 -> 0x0002, carry=1.
//  3. ADD 0x7FFF + 0x0001 -> 0x8000, ovf=1, carry=0.
//     SUB 0x8000 - 0x0001 -> 0x7FFF, ovf=1.
//  4. AND 0xF0F0 & 0x3C3C -> 0x3030; OR -> 0xFCFC; carry=0, ovf=0.
//     AND 0x00FF & 0xFF00 -> zero=1.
//  5. Hold out_ready=0 for 5 cycles in DONE -> outputs stable, in_ready=0,
//     and an in_valid pulse is ignored. Then out_ready=1 -> IDLE the next cycle.
//  6. Assert rst_n=0 in BUSY slice 2 -> out_valid=0 and result=0 at once.
//     After release, a fresh ADD 1+1=2 is correct.
//     Repeat 1 with WIDTH=8, SLICE_W=8: latency 1.

Source files
------------

// File: rtl/alu_seq_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// alu_seq_pkg : op/state encodings and flag bundle for the sequential ALU
// Rev 1.0
// ---------------------------------------------------------------------------
package alu_seq_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_OR  = 2'b11
  } op_e;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef struct packed {
    logic carry;
    logic ovf;
    logic zero;
  } flags_t;

  function automatic logic is_arith(input logic [1:0] op);
    return ~op[1];
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_seq_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// alu_seq_if : request/response handshake bundle of the sequential ALU
// Rev 1.0
// ---------------------------------------------------------------------------
interface alu_seq_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_op;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic             out_carry;
  logic             out_ovf;
  logic             out_zero;

  modport master (
    output in_valid, in_op, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_result, out_carry, out_ovf, out_zero
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, out_ready,
    output in_ready, out_valid, out_result, out_carry, out_ovf, out_zero
  );
endinterface
`default_nettype wire

// File: rtl/alu_seq_chunk.sv
`default_nettype none
// ---------------------------------------------------------------------------
// alu_seq_chunk : combinational SLICE_W-bit ripple slice (ADD/SUB/AND/OR)
// Rev 1.0
// ---------------------------------------------------------------------------
module alu_seq_chunk
  import alu_seq_pkg::*;
#(
  parameter int SLICE_W = 4
) (
  input  logic [1:0]         op_i,
  input  logic [SLICE_W-1:0] a_i,
  input  logic [SLICE_W-1:0] b_i,
  input  logic               cin_i,
  output logic [SLICE_W-1:0] o_o,
  output logic               cout_o,
  output logic               cmsb_o
);

  logic [SLICE_W-1:0] bx;
  logic [SLICE_W-1:0] sum;
  logic [SLICE_W:0]   c;

  // Subtraction is a + ~b with the carry register preloaded to 1 on accept
  assign bx   = (op_i == OP_SUB) ? ~b_i : b_i;
  assign c[0] = cin_i;

  for (genvar i = 0; i < SLICE_W; i++) begin : g_bit
    assign sum[i]  = a_i[i] ^ bx[i] ^ c[i];
    assign c[i+1]  = (a_i[i] & bx[i]) | (c[i] & (a_i[i] ^ bx[i]));
  end

  always_comb begin
    o_o    = sum;
    cout_o = c[SLICE_W];
    cmsb_o = c[SLICE_W-1];
    if (!is_arith(op_i)) begin
      o_o    = (op_i == OP_OR) ? (a_i | b_i) : (a_i & b_i);
      cout_o = 1'b0;
      cmsb_o = 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// alu_seq : multi-cycle WIDTH-bit ALU, SLICE_W bits per clock, with flags
// Rev 1.0
// ---------------------------------------------------------------------------
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int SLICE_W = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  alu_seq_if.slave  bus
);

  localparam int NSLICE = WIDTH / SLICE_W;
  localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NSLICE - 1);

  if ((SLICE_W < 1) || (WIDTH % SLICE_W != 0)) begin : g_bad_cfg
    $error("alu_seq: WIDTH must be a non-zero multiple of SLICE_W");
  end

  logic [1:0]         state_q, state_d;
  logic [1:0]         op_q;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [WIDTH-1:0]   res_q, res_d;
  logic               carry_q;
  logic [CNT_W-1:0]   idx_q;
  flags_t             flags_q, flags_d;

  logic [SLICE_W-1:0] slice_a, slice_b, slice_o;
  logic               slice_cout, slice_cmsb;
  logic               last;

  assign slice_a = a_q[idx_q*SLICE_W +: SLICE_W];
  assign slice_b = b_q[idx_q*SLICE_W +: SLICE_W];
  assign last    = (idx_q == LAST_IDX);

  alu_seq_chunk #(
    .SLICE_W (SLICE_W)
  ) u_chunk (
    .op_i   (op_q),
    .a_i    (slice_a),
    .b_i    (slice_b),
    .cin_i  (carry_q),
    .o_o    (slice_o),
    .cout_o (slice_cout),
    .cmsb_o (slice_cmsb)
  );

  // Zero must see the slice being written this cycle, so it is taken from res_d
  always_comb begin
    res_d = res_q;
    res_d[idx_q*SLICE_W +: SLICE_W] = slice_o;
    flags_d.carry = slice_cout;
    flags_d.ovf   = slice_cmsb ^ slice_cout;
    flags_d.zero  = (res_d == '0);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (bus.in_valid)  state_d = ST_BUSY;
      ST_BUSY: if (last)          state_d = ST_DONE;
      ST_DONE: if (bus.out_ready) state_d = ST_IDLE;
      default:                    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: begin
          if (bus.in_valid) begin
            op_q    <= bus.in_op;
            a_q     <= bus.in_a;
            b_q     <= bus.in_b;
            carry_q <= is_arith(bus.in_op) & bus.in_op[0];
            idx_q   <= '0;
          end
        end
        ST_BUSY: begin
          res_q   <= res_d;
          carry_q <= slice_cout;
          idx_q   <= last ? '0 : idx_q + 1'b1;
          if (last) flags_q <= flags_d;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready   = (state_q == ST_IDLE);
  assign bus.out_valid  = (state_q == ST_DONE);
  assign bus.out_result = res_q;
  assign bus.out_carry  = flags_q.carry;
  assign bus.out_ovf    = flags_q.ovf;
  assign bus.out_zero   = flags_q.zero;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_alu_seq : scoreboard bench for alu_seq in 16/4 and 8/8 configurations
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_alu_seq;
  import alu_seq_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  typedef struct {
    logic [15:0] res;
    logic        c;
    logic        v;
    logic        z;
    int          acc;
  } exp_t;

  exp_t q16[$];
  exp_t q8[$];
  logic prev16 = 1'b0;
  logic prev8  = 1'b0;

  alu_seq_if #(.WIDTH(16)) if16 ();
  alu_seq_if #(.WIDTH(8))  if8 ();

  alu_seq #(.WIDTH(16), .SLICE_W(4)) dut16 (.clk(clk), .rst_n(rst_n), .bus(if16.slave));
  alu_seq #(.WIDTH(8),  .SLICE_W(8)) dut8  (.clk(clk), .rst_n(rst_n), .bus(if8.slave));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: whole-word arithmetic modulo 2^w; flags from sign rules
  function automatic exp_t model(input int w, input logic [1:0] op,
                                 input logic [15:0] a, input logic [15:0] b);
    exp_t e;
    logic [16:0] m, full;
    logic sa, sb, sr;
    m = (17'd1 << w) - 17'd1;
    case (op)
      2'b00:   full = ({1'b0, a} & m) + ({1'b0, b} & m);
      2'b01:   full = ({1'b0, a} & m) + ((~{1'b0, b}) & m) + 17'd1;
      2'b10:   full = {1'b0, a & b} & m;
      default: full = {1'b0, a | b} & m;
    endcase
    e.res = full[15:0] & m[15:0];
    sa = a[w-1];
    sb = b[w-1];
    sr = e.res[w-1];
    e.c = op[1] ? 1'b0 : full[w];
    case (op)
      2'b00:   e.v = (sa == sb) && (sr != sa);
      2'b01:   e.v = (sa != sb) && (sr != sa);
      default: e.v = 1'b0;
    endcase
    e.z = (e.res == 16'h0);
    e.acc = 0;
    return e;
  endfunction

  function automatic logic [15:0] pick();
    case ($urandom_range(0, 5))
      0:       return 16'h0000;
      1:       return 16'hFFFF;
      2:       return 16'h7FFF;
      3:       return 16'h8000;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic check_out(input string tag, input exp_t e, input logic [15:0] res,
                           input logic c, input logic v, input logic z, input int lat);
    chk({tag, "_result"},  res, e.res);
    chk({tag, "_carry"},   c, e.c);
    chk({tag, "_ovf"},     v, e.v);
    chk({tag, "_zero"},    z, e.z);
    chk({tag, "_latency"}, cyc - e.acc, lat);
  endtask

  // Monitors: compare on every rising edge of out_valid
  always @(negedge clk) begin
    if (!rst_n) begin
      prev16 = 1'b0;
      prev8  = 1'b0;
    end else begin
      if (if16.out_valid && !prev16) begin
        if (q16.size() == 0) chk("m16_unexpected_output", 1, 0);
        else check_out("m16", q16.pop_front(), if16.out_result, if16.out_carry,
                       if16.out_ovf, if16.out_zero, 4);
      end
      if (if8.out_valid && !prev8) begin
        if (q8.size() == 0) chk("m8_unexpected_output", 1, 0);
        else check_out("m8", q8.pop_front(), {8'h00, if8.out_result}, if8.out_carry,
                       if8.out_ovf, if8.out_zero, 1);
      end
      prev16 = if16.out_valid;
      prev8  = if8.out_valid;
    end
  end

  task automatic issue(input bit b8, input logic [1:0] op, input logic [15:0] a,
                       input logic [15:0] b, input bit push);
    int n;
    exp_t e;
    n = 0;
    @(negedge clk);
    while (!(b8 ? if8.in_ready : if16.in_ready) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("in_ready_timeout", 0, 1);
    if (b8) begin
      if8.in_valid = 1'b1; if8.in_op = op; if8.in_a = a[7:0]; if8.in_b = b[7:0];
    end else begin
      if16.in_valid = 1'b1; if16.in_op = op; if16.in_a = a; if16.in_b = b;
    end
    @(posedge clk);
    #1;
    e = model(b8 ? 8 : 16, op, b8 ? {8'h00, a[7:0]} : a, b8 ? {8'h00, b[7:0]} : b);
    e.acc = cyc;
    if (push) begin
      if (b8) q8.push_back(e);
      else    q16.push_back(e);
    end
    // Scramble inputs after accept; the in-flight result must not change
    if (b8) begin
      if8.in_valid = 1'b0; if8.in_op = 2'($urandom); if8.in_a = 8'($urandom); if8.in_b = 8'($urandom);
    end else begin
      if16.in_valid = 1'b0; if16.in_op = 2'($urandom); if16.in_a = 16'($urandom); if16.in_b = 16'($urandom);
    end
  endtask

  task automatic finish_op(input bit b8, input int hold);
    int n;
    n = 0;
    while (!(b8 ? if8.out_valid : if16.out_valid) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!(b8 ? if8.out_valid : if16.out_valid)) chk("out_valid_timeout", 0, 1);
    repeat (hold) @(negedge clk);
    if (b8) if8.out_ready = 1'b1; else if16.out_ready = 1'b1;
    @(posedge clk);
    #1;
    if (b8) if8.out_ready = 1'b0; else if16.out_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int n;
    logic [1:0] op;
    if16.in_valid = 1'b0; if16.in_op = 2'b00; if16.in_a = '0; if16.in_b = '0; if16.out_ready = 1'b0;
    if8.in_valid  = 1'b0; if8.in_op  = 2'b00; if8.in_a  = '0; if8.in_b  = '0; if8.out_ready  = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready",  if16.in_ready, 1);
    chk("rst_out_valid", if16.out_valid, 0);
    chk("rst_result",    if16.out_result, 0);
    chk("rst_flags",     {if16.out_carry, if16.out_ovf, if16.out_zero}, 0);
    chk("rst8_in_ready", if8.in_ready, 1);
    chk("rst8_out_valid", if8.out_valid, 0);

    issue(0, OP_ADD, 16'hFFFF, 16'h0001, 1); finish_op(0, 0);
    issue(0, OP_SUB, 16'h0005, 16'h0007, 1); finish_op(0, 0);
    issue(0, OP_SUB, 16'h0007, 16'h0005, 1); finish_op(0, 1);
    issue(0, OP_ADD, 16'h7FFF, 16'h0001, 1); finish_op(0, 0);
    issue(0, OP_SUB, 16'h8000, 16'h0001, 1); finish_op(0, 0);
    issue(0, OP_AND, 16'hF0F0, 16'h3C3C, 1); finish_op(0, 0);
    issue(0, OP_OR,  16'hF0F0, 16'h3C3C, 1); finish_op(0, 2);
    issue(0, OP_AND, 16'h00FF, 16'hFF00, 1); finish_op(0, 0);

    // Back-pressure in DONE: outputs stable, no accept of a stray request
    issue(0, OP_OR, 16'h1234, 16'h00F0, 1);
    e = model(16, OP_OR, 16'h1234, 16'h00F0);
    n = 0;
    while (!if16.out_valid && n < 50) begin @(negedge clk); n++; end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_out_valid", if16.out_valid, 1);
      chk("hold_in_ready",  if16.in_ready, 0);
      chk("hold_result",    if16.out_result, e.res);
      chk("hold_flags",     {if16.out_carry, if16.out_ovf, if16.out_zero}, {e.c, e.v, e.z});
      if (i == 1) begin
        if16.in_valid = 1'b1; if16.in_op = OP_ADD; if16.in_a = 16'h0101; if16.in_b = 16'h0202;
      end else begin
        if16.in_valid = 1'b0;
      end
    end
    if16.in_valid  = 1'b0;
    if16.out_ready = 1'b1;
    @(posedge clk);
    #1;
    if16.out_ready = 1'b0;
    chk("release_out_valid", if16.out_valid, 0);
    chk("release_in_ready",  if16.in_ready, 1);

    // Reset while slice 2 is in flight
    issue(0, OP_ADD, 16'h1111, 16'h2222, 0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", if16.out_valid, 0);
    chk("midrst_result",    if16.out_result, 0);
    chk("midrst_in_ready",  if16.in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    issue(0, OP_ADD, 16'h0001, 16'h0001, 1); finish_op(0, 0);

    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      issue(0, op, pick(), pick(), 1);
      if ($urandom_range(0, 1) == 1) if16.out_ready = 1'b1;
      finish_op(0, $urandom_range(0, 2));
    end

    issue(1, OP_ADD, 16'h00FF, 16'h0001, 1); finish_op(1, 0);
    for (int i = 0; i < 15; i++) begin
      op = 2'($urandom_range(0, 3));
      issue(1, op, pick(), pick(), 1);
      finish_op(1, $urandom_range(0, 2));
    end

    repeat (3) @(negedge clk);
    chk("q16_drained", q16.size(), 0);
    chk("q8_drained",  q8.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
